float_accumulate: RTL and testbench

//   Sequential fp16 stream accumulator. Sits directly downstream of float_add:

---
 rtl/float_accumulate_pkg.sv | 25 ++
 rtl/float_accumulate_float_add.sv | 122 ++++++++++++
 rtl/float_accumulate.sv | 88 ++++++++
 tb/tb_float_accumulate.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/float_accumulate_pkg.sv
// Shared fp16 layout, field-slice macros and FSM encoding for the fp16 stream accumulator.
`ifndef FLOAT_ACCUMULATE_PKG_SV
`define FLOAT_ACCUMULATE_PKG_SV

package float_accumulate_pkg;

  localparam int float_width    = 16;
  localparam int exponent_width = 5;
  localparam int mantissa_width = 10;

  localparam logic [exponent_width-1:0] EXP_ALL_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_t;

endpackage

`define FP_SIGN(f) f[float_accumulate_pkg::float_width-1]
`define FP_EXP(f)  f[float_accumulate_pkg::float_width-2 -: float_accumulate_pkg::exponent_width]
`define FP_MANT(f) f[float_accumulate_pkg::mantissa_width-1:0]

`endif

// File: rtl/float_accumulate_float_add.sv
// Combinational fp16 adder: align, add/subtract, normalise, round-to-nearest-even.
// Subnormals are handled gradually; overflow saturates to Inf, invalid ops give a quiet NaN.
module float_add
  import float_accumulate_pkg::*;
(
  input  logic [float_width-1:0] float_a,
  input  logic [float_width-1:0] float_b,
  output logic [float_width-1:0] res
);

  localparam int SIG_W = mantissa_width + 1;
  localparam int EXT_W = SIG_W + 3;
  localparam int EXW   = exponent_width + 2;
  localparam logic [EXW-1:0]   EXT_W_E   = EXW'(EXT_W);
  localparam logic [EXW-1:0]   EXP_MAX_E = EXW'(EXP_ALL_ONES);
  localparam logic [EXW-1:0]   ONE_E     = EXW'(1);
  localparam logic [EXT_W-1:0] ONE_EXT   = EXT_W'(1);

  logic                      sign_a, sign_b;
  logic [exponent_width-1:0] exp_a, exp_b;
  logic [mantissa_width-1:0] man_a, man_b;
  logic                      a_inf, b_inf, a_nan, b_nan;
  logic                      a_big, sign_big;
  logic [EXW-1:0]            eff_a, eff_b, e_big, e_small, diff;
  logic [SIG_W-1:0]          sig_a, sig_b, sig_big, sig_small;
  logic [EXT_W-1:0]          big_ext, small_ext, aligned, lost_mask;
  logic [EXT_W:0]            sum;
  logic [EXW-1:0]            lz, max_shift, shift, e_norm, e_final;
  logic [EXT_W-1:0]          norm;
  logic                      round_up;
  logic [SIG_W:0]            rounded;
  logic [mantissa_width-1:0] m_final;

  assign sign_a = `FP_SIGN(float_a);
  assign sign_b = `FP_SIGN(float_b);
  assign exp_a  = `FP_EXP(float_a);
  assign exp_b  = `FP_EXP(float_b);
  assign man_a  = `FP_MANT(float_a);
  assign man_b  = `FP_MANT(float_b);

  assign a_inf = (exp_a == EXP_ALL_ONES) && (man_a == '0);
  assign b_inf = (exp_b == EXP_ALL_ONES) && (man_b == '0);
  assign a_nan = (exp_a == EXP_ALL_ONES) && (man_a != '0);
  assign b_nan = (exp_b == EXP_ALL_ONES) && (man_b != '0);

  // Subnormals share the exponent of the smallest normal but have no hidden one.
  assign eff_a = (exp_a == '0) ? ONE_E : EXW'(exp_a);
  assign eff_b = (exp_b == '0) ? ONE_E : EXW'(exp_b);
  assign sig_a = {exp_a != '0, man_a};
  assign sig_b = {exp_b != '0, man_b};

  always_comb begin
    a_big     = {exp_a, man_a} >= {exp_b, man_b};
    sign_big  = a_big ? sign_a : sign_b;
    e_big     = a_big ? eff_a : eff_b;
    e_small   = a_big ? eff_b : eff_a;
    sig_big   = a_big ? sig_a : sig_b;
    sig_small = a_big ? sig_b : sig_a;
    diff      = e_big - e_small;
    big_ext   = {sig_big, 3'b000};
    small_ext = {sig_small, 3'b000};
    lost_mask = '0;
    aligned   = '0;
    // Bits shifted out of the smaller operand collapse into a sticky LSB.
    if (diff >= EXT_W_E) begin
      aligned = {{(EXT_W-1){1'b0}}, |small_ext};
    end else begin
      lost_mask = (ONE_EXT << diff) - ONE_EXT;
      aligned   = (small_ext >> diff) | {{(EXT_W-1){1'b0}}, |(small_ext & lost_mask)};
    end
    if (sign_a == sign_b) sum = {1'b0, big_ext} + {1'b0, aligned};
    else                  sum = {1'b0, big_ext} - {1'b0, aligned};
  end

  always_comb begin
    lz = EXT_W_E;
    for (int i = 0; i < EXT_W; i++) begin
      if (sum[i]) lz = EXW'(EXT_W - 1 - i);
    end
    max_shift = e_big - ONE_E;
    shift     = (lz < max_shift) ? lz : max_shift;
    if (sum[EXT_W]) begin
      norm   = sum[EXT_W:1] | {{(EXT_W-1){1'b0}}, sum[0]};
      e_norm = e_big + ONE_E;
    end else begin
      norm   = sum[EXT_W-1:0] << shift;
      e_norm = e_big - shift;
    end
  end

  // A rounding carry either bumps the exponent or lifts a subnormal into the normal range.
  always_comb begin
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[EXT_W-1:3]} + {{SIG_W{1'b0}}, round_up};
    if (rounded[SIG_W]) begin
      e_final = e_norm + ONE_E;
      m_final = rounded[mantissa_width:1];
    end else if (rounded[SIG_W-1]) begin
      e_final = e_norm;
      m_final = rounded[mantissa_width-1:0];
    end else begin
      e_final = '0;
      m_final = rounded[mantissa_width-1:0];
    end
  end

  always_comb begin
    if (a_nan || b_nan || (a_inf && b_inf && (sign_a != sign_b)))
      res = {1'b0, EXP_ALL_ONES, 1'b1, {(mantissa_width-1){1'b0}}};
    else if (a_inf)
      res = float_a;
    else if (b_inf)
      res = float_b;
    else if (sum == '0)
      res = {sign_a & sign_b, {(float_width-1){1'b0}}};
    else if (e_final >= EXP_MAX_E)
      res = {sign_big, EXP_ALL_ONES, {mantissa_width{1'b0}}};
    else
      res = {sign_big, e_final[exponent_width-1:0], m_final};
  end

endmodule

// File: rtl/float_accumulate.sv
// fp16 stream accumulator: sums each in_last-delimited packet through float_add
// and presents one sum, element count and sticky overflow flag per packet.
module float_accumulate
  import float_accumulate_pkg::*;
#(
  parameter int count_width = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [float_width-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [float_width-1:0] out_sum,
  output logic [count_width-1:0] out_count,
  output logic                   out_ovf
);

  acc_state_t             state, next_state;
  logic [float_width-1:0] acc, acc_next, add_res;
  logic [count_width-1:0] count;
  logic                   ovf;
  logic                   load_first, load_accum;

  float_add u_float_add (
    .float_a (acc),
    .float_b (in_data),
    .res     (add_res)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load_first = 1'b0;
    load_accum = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          load_first = 1'b1;
          next_state = in_last ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          load_accum = 1'b1;
          if (in_last) next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = !rst;
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // The first element is loaded raw so a single-element packet returns it bit-exact.
  assign acc_next = load_first ? in_data : add_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (load_first || load_accum) begin
      acc   <= acc_next;
      count <= load_first ? count_width'(1)
             : (&count)   ? count
             :              count + count_width'(1);
      ovf   <= (load_accum & ovf) | (`FP_EXP(acc_next) == EXP_ALL_ONES);
    end
  end

  assign out_sum   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_float_accumulate.sv
// Directed self-checking bench for float_accumulate with an expected-result scoreboard.
module tb_float_accumulate;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  typedef struct {
    logic [15:0] sum;
    logic [7:0]  count;
    logic        ovf;
  } expect_t;

  expect_t sb[$];
  int tests_run    = 0;
  int tests_failed = 0;

  float_accumulate dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input logic [15:0] s, input logic [7:0] c, input logic o);
    expect_t e;
    e.sum   = s;
    e.count = c;
    e.ovf   = o;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [15:0] data, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) compare("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Called right after the last beat is accepted, so out_valid must already be up.
  task automatic checkOutput(input int hold);
    expect_t e;
    int guard;
    guard = 0;
    while (!out_valid && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    compare("out_valid_seen", 32'(out_valid), 32'd1);
    compare("latency", 32'(guard), 32'd0);
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      compare("hold_valid", 32'(out_valid), 32'd1);
      compare("hold_sum", 32'(out_sum), 32'(e.sum));
      compare("hold_in_ready", 32'(in_ready), 32'd0);
    end
    compare("out_sum", 32'(out_sum), 32'(e.sum));
    compare("out_count", 32'(out_count), 32'(e.count));
    compare("out_ovf", 32'(out_ovf), 32'(e.ovf));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    compare("post_valid", 32'(out_valid), 32'd0);
    compare("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset held for two cycles.
    bubble(2);
    compare("rst_out_valid", 32'(out_valid), 32'd0);
    compare("rst_in_ready", 32'(in_ready), 32'd0);
    compare("rst_out_sum", 32'(out_sum), 32'h0000);
    compare("rst_out_count", 32'(out_count), 32'd0);
    compare("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst = 1'b0;
    bubble(1);
    compare("idle_in_ready", 32'(in_ready), 32'd1);

    // 1.0 + 2.0
    pushExpect(16'h4200, 8'd2, 1'b0);
    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h4000, 1'b1);
    checkOutput(0);

    // Four 1.0 elements with single-cycle bubbles between beats.
    pushExpect(16'h4400, 8'd4, 1'b0);
    applyStimulus(16'h3C00, 1'b0);
    bubble(1);
    applyStimulus(16'h3C00, 1'b0);
    bubble(1);
    applyStimulus(16'h3C00, 1'b0);
    bubble(1);
    applyStimulus(16'h3C00, 1'b1);
    checkOutput(0);

    // Single element held against backpressure.
    pushExpect(16'h34CD, 8'd1, 1'b0);
    applyStimulus(16'h34CD, 1'b1);
    checkOutput(5);

    // Subtraction with renormalisation, then exact cancellation.
    pushExpect(16'h3C00, 8'd2, 1'b0);
    applyStimulus(16'h4200, 1'b0);
    applyStimulus(16'hC000, 1'b1);
    checkOutput(0);
    pushExpect(16'h0000, 8'd2, 1'b0);
    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'hBC00, 1'b1);
    checkOutput(0);

    // 2^15 + 2^15 overflows to +Inf.
    pushExpect(16'h7C00, 8'd2, 1'b1);
    applyStimulus(16'h7800, 1'b0);
    applyStimulus(16'h7800, 1'b1);
    checkOutput(0);

    // Overflow flag stays set after a further negative element.
    pushExpect(16'h7C00, 8'd3, 1'b1);
    applyStimulus(16'h7800, 1'b0);
    applyStimulus(16'h7800, 1'b0);
    applyStimulus(16'hF800, 1'b1);
    checkOutput(0);

    // 300 zero elements saturate the count.
    pushExpect(16'h0000, 8'hFF, 1'b0);
    for (int i = 0; i < 300; i++) applyStimulus(16'h0000, (i == 299));
    checkOutput(0);

    // Reset during the third beat of a packet discards it.
    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h3C00, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h3C00;
    in_last  = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    compare("midrst_out_valid", 32'(out_valid), 32'd0);
    compare("midrst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      compare("midrst_no_output", 32'(out_valid), 32'd0);
    end
    pushExpect(16'h4000, 8'd1, 1'b0);
    applyStimulus(16'h4000, 1'b1);
    checkOutput(0);

    compare("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
